// File: rtl/ecc_link_master.sv
// rtl/ecc_link_master.sv - Host-side bit-serial link master for the ECC serial wrapper
//
// Accepts parallel P*a and Pb jobs over valid/ready and serialises them into
// the wrapper's input protocol (start pulse, 2 mode bits, operands MSB-first).
// Captures the wrapper's bit-serial Pa/Pab result frames into a one-entry
// parallel result buffer.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-low reset
//   i_job_*, o_job_ready           P*a job: mode (0=32,1=64,2=128,3=256), P, ax, ay, prime
//   i_pbj_*, o_pbj_ready           Pb job: x, y (frame length from current mode)
//   o_p_a_valid, o_mode, o_P, o_ax, o_ay, o_prime   serial P*a frame
//   o_pb_valid, o_Pbx, o_Pby       serial Pb frame
//   i_Pa_valid, i_Pax, i_Pay       serial Pa result
//   i_Pab_valid, i_Pabx, i_Paby    serial Pab result
//   o_res_valid, i_res_ready       result handshake
//   o_res_kind, o_res_x, o_res_y   result (0=Pa, 1=Pab), zero-extended
//   o_err                          sticky protocol/overflow error
module ecc_link_master #(
  parameter int MAX_BITS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_job_valid,
  output logic                o_job_ready,
  input  logic [1:0]          i_job_mode,
  input  logic [MAX_BITS-1:0] i_job_P,
  input  logic [MAX_BITS-1:0] i_job_ax,
  input  logic [MAX_BITS-1:0] i_job_ay,
  input  logic [MAX_BITS-1:0] i_job_prime,
  input  logic                i_pbj_valid,
  output logic                o_pbj_ready,
  input  logic [MAX_BITS-1:0] i_pbj_x,
  input  logic [MAX_BITS-1:0] i_pbj_y,
  output logic                o_p_a_valid,
  output logic                o_mode,
  output logic                o_P,
  output logic                o_ax,
  output logic                o_ay,
  output logic                o_prime,
  output logic                o_pb_valid,
  output logic                o_Pbx,
  output logic                o_Pby,
  input  logic                i_Pa_valid,
  input  logic                i_Pax,
  input  logic                i_Pay,
  input  logic                i_Pab_valid,
  input  logic                i_Pabx,
  input  logic                i_Paby,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic                o_res_kind,
  output logic [MAX_BITS-1:0] o_res_x,
  output logic [MAX_BITS-1:0] o_res_y,
  output logic                o_err
);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_MODE, TX_DATA, TX_PBSTART, TX_PBDATA
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_PA, RX_PAB
  } rx_state_t;

  // Index of the MSB of an N-bit operand for a given mode.
  function automatic logic [7:0] f_last(input logic [1:0] m);
    case (m)
      2'd0:    f_last = 8'd31;
      2'd1:    f_last = 8'd63;
      2'd2:    f_last = 8'd127;
      default: f_last = 8'd255;
    endcase
  endfunction

  tx_state_t           r_tx_state, w_tx_nxt;
  logic [7:0]          r_cnt, w_cnt_nxt;
  logic [1:0]          r_cur_mode;
  logic [MAX_BITS-1:0] r_P, r_ax, r_ay, r_prime, r_pbx, r_pby;

  logic       w_acc_job, w_acc_pbj;
  logic       w_p_a_valid, w_mode, w_P, w_ax, w_ay, w_prime;
  logic       w_pb_valid, w_Pbx, w_Pby;
  logic [7:0] w_last, w_idx;

  assign w_last      = f_last(r_cur_mode);
  assign w_idx       = r_cnt - 8'd1;
  assign o_job_ready = (r_tx_state == TX_IDLE);
  assign o_pbj_ready = (r_tx_state == TX_IDLE);

  // Serial outputs are registered, so each branch computes the value to be
  // presented during the *next* cycle.
  always_comb begin
    w_tx_nxt    = r_tx_state;
    w_cnt_nxt   = r_cnt;
    w_acc_job   = 1'b0;
    w_acc_pbj   = 1'b0;
    w_p_a_valid = 1'b0;
    w_mode      = 1'b0;
    w_P         = 1'b0;
    w_ax        = 1'b0;
    w_ay        = 1'b0;
    w_prime     = 1'b0;
    w_pb_valid  = 1'b0;
    w_Pbx       = 1'b0;
    w_Pby       = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (i_job_valid) begin
          w_acc_job   = 1'b1;
          w_tx_nxt    = TX_START;
          w_p_a_valid = 1'b1;
        end else if (i_pbj_valid) begin
          w_acc_pbj  = 1'b1;
          w_tx_nxt   = TX_PBSTART;
          w_pb_valid = 1'b1;
        end
      end
      TX_START: begin
        w_tx_nxt  = TX_MODE;
        w_cnt_nxt = 8'd1;
        w_mode    = r_cur_mode[1];
      end
      TX_MODE: begin
        if (r_cnt == 8'd0) begin
          w_tx_nxt  = TX_DATA;
          w_cnt_nxt = w_last;
          w_P       = r_P[w_last];
          w_ax      = r_ax[w_last];
          w_ay      = r_ay[w_last];
          w_prime   = r_prime[w_last];
        end else begin
          w_cnt_nxt = 8'd0;
          w_mode    = r_cur_mode[0];
        end
      end
      TX_DATA: begin
        if (r_cnt == 8'd0) begin
          w_tx_nxt = TX_IDLE;
        end else begin
          w_cnt_nxt = w_idx;
          w_P       = r_P[w_idx];
          w_ax      = r_ax[w_idx];
          w_ay      = r_ay[w_idx];
          w_prime   = r_prime[w_idx];
        end
      end
      TX_PBSTART: begin
        w_tx_nxt  = TX_PBDATA;
        w_cnt_nxt = w_last;
        w_Pbx     = r_pbx[w_last];
        w_Pby     = r_pby[w_last];
      end
      TX_PBDATA: begin
        if (r_cnt == 8'd0) begin
          w_tx_nxt = TX_IDLE;
        end else begin
          w_cnt_nxt = w_idx;
          w_Pbx     = r_pbx[w_idx];
          w_Pby     = r_pby[w_idx];
        end
      end
      default: w_tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state  <= TX_IDLE;
      r_cnt       <= 8'd0;
      r_cur_mode  <= 2'd0;
      r_P         <= '0;
      r_ax        <= '0;
      r_ay        <= '0;
      r_prime     <= '0;
      r_pbx       <= '0;
      r_pby       <= '0;
      o_p_a_valid <= 1'b0;
      o_mode      <= 1'b0;
      o_P         <= 1'b0;
      o_ax        <= 1'b0;
      o_ay        <= 1'b0;
      o_prime     <= 1'b0;
      o_pb_valid  <= 1'b0;
      o_Pbx       <= 1'b0;
      o_Pby       <= 1'b0;
    end else begin
      r_tx_state  <= w_tx_nxt;
      r_cnt       <= w_cnt_nxt;
      o_p_a_valid <= w_p_a_valid;
      o_mode      <= w_mode;
      o_P         <= w_P;
      o_ax        <= w_ax;
      o_ay        <= w_ay;
      o_prime     <= w_prime;
      o_pb_valid  <= w_pb_valid;
      o_Pbx       <= w_Pbx;
      o_Pby       <= w_Pby;
      if (w_acc_job) begin
        r_cur_mode <= i_job_mode;
        r_P        <= i_job_P;
        r_ax       <= i_job_ax;
        r_ay       <= i_job_ay;
        r_prime    <= i_job_prime;
      end
      if (w_acc_pbj) begin
        r_pbx <= i_pbj_x;
        r_pby <= i_pbj_y;
      end
    end
  end

  // ---------------------------------------------------------------- receive
  rx_state_t           r_rx_state, w_rx_nxt;
  logic [7:0]          r_rx_cnt, w_rx_cnt_nxt;   // bits still to come
  logic [MAX_BITS-1:0] r_rx_x, r_rx_y;
  logic                w_rx_start, w_rx_shift, w_rx_bx, w_rx_by;
  logic                w_commit, w_commit_kind, w_proto_err, w_full_block;

  always_comb begin
    w_rx_nxt      = r_rx_state;
    w_rx_cnt_nxt  = r_rx_cnt;
    w_rx_start    = 1'b0;
    w_rx_shift    = 1'b0;
    w_rx_bx       = 1'b0;
    w_rx_by       = 1'b0;
    w_commit      = 1'b0;
    w_commit_kind = 1'b0;
    w_proto_err   = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (i_Pa_valid) begin
          w_rx_nxt     = RX_PA;
          w_rx_start   = 1'b1;
          w_rx_bx      = i_Pax;
          w_rx_by      = i_Pay;
          w_rx_cnt_nxt = f_last(r_cur_mode);
          w_proto_err  = i_Pab_valid;
        end else if (i_Pab_valid) begin
          w_rx_nxt     = RX_PAB;
          w_rx_start   = 1'b1;
          w_rx_bx      = i_Pabx;
          w_rx_by      = i_Paby;
          w_rx_cnt_nxt = f_last(r_cur_mode);
        end
      end
      RX_PA, RX_PAB: begin
        if ((r_rx_state == RX_PA) ? i_Pa_valid : i_Pab_valid) begin
          w_rx_shift = 1'b1;
          w_rx_bx    = (r_rx_state == RX_PA) ? i_Pax : i_Pabx;
          w_rx_by    = (r_rx_state == RX_PA) ? i_Pay : i_Paby;
          if (r_rx_cnt == 8'd1) begin
            w_commit      = 1'b1;
            w_commit_kind = (r_rx_state == RX_PAB);
            w_rx_nxt      = RX_IDLE;
          end else begin
            w_rx_cnt_nxt = r_rx_cnt - 8'd1;
          end
        end else begin
          w_proto_err = 1'b1;
          w_rx_nxt    = RX_IDLE;
        end
      end
      default: w_rx_nxt = RX_IDLE;
    endcase
  end

  // Slot is blocked only if it stays occupied through this edge.
  assign w_full_block = o_res_valid & ~i_res_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= 8'd0;
      r_rx_x      <= '0;
      r_rx_y      <= '0;
      o_res_valid <= 1'b0;
      o_res_kind  <= 1'b0;
      o_res_x     <= '0;
      o_res_y     <= '0;
      o_err       <= 1'b0;
    end else begin
      r_rx_state <= w_rx_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      if (w_rx_start) begin
        r_rx_x <= {{(MAX_BITS-1){1'b0}}, w_rx_bx};
        r_rx_y <= {{(MAX_BITS-1){1'b0}}, w_rx_by};
      end else if (w_rx_shift) begin
        r_rx_x <= {r_rx_x[MAX_BITS-2:0], w_rx_bx};
        r_rx_y <= {r_rx_y[MAX_BITS-2:0], w_rx_by};
      end
      if (w_commit && !w_full_block) begin
        o_res_valid <= 1'b1;
        o_res_kind  <= w_commit_kind;
        o_res_x     <= {r_rx_x[MAX_BITS-2:0], w_rx_bx};
        o_res_y     <= {r_rx_y[MAX_BITS-2:0], w_rx_by};
      end else if (o_res_valid && i_res_ready) begin
        o_res_valid <= 1'b0;
      end
      if (w_proto_err || (w_commit && w_full_block)) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule
